// File: rtl/ptr_mem_unit.sv
// Pointer-indirect load/store sequencer: reads a pointer pair, runs one bus access, writes back.
// Optional REQ watchdog enabled by defining PTR_MEM_TIMEOUT_EN.
module ptr_mem_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_is_load,
    input  logic [1:0]  i_mode,
    input  logic [3:0]  i_rd,
    input  logic [3:0]  i_rp,
    input  logic [7:0]  i_ptr_lo,
    input  logic [7:0]  i_ptr_hi,
    input  logic [7:0]  i_rd_data,
    output logic [3:0]  o_rd_sel,
    output logic [3:0]  o_ptr_sel,
    output logic        o_wr_en,
    output logic [7:0]  o_wr_data,
    output logic        o_inc,
    output logic        o_dec,
    output logic [15:0] o_mem_addr,
    output logic [7:0]  o_mem_wdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    input  logic [7:0]  i_mem_rdata,
    input  logic        i_mem_ack,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    typedef enum logic [1:0] {StIdle, StLatch, StReq, StWb} state_e;

    state_e      r_state;
    logic        r_is_load;
    logic [1:0]  r_mode;
    logic [3:0]  r_rd;
    logic [3:0]  r_rp;
    logic [15:0] r_mem_addr;
    logic [7:0]  r_mem_wdata;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [7:0]  r_wr_data;
    logic        r_wr_en;
    logic        r_inc;
    logic        r_dec;
    logic        r_done;

    logic        w_hazard;
    logic        w_do_inc;
    logic        w_do_dec;

    // A load landing in its own pointer pair must not be clobbered by the pointer update.
    assign w_hazard = r_is_load && (r_rd[3:1] == r_rp[3:1]);
    assign w_do_inc = (r_mode == 2'b01) && !w_hazard;
    assign w_do_dec = (r_mode == 2'b10) && !w_hazard;

`ifdef PTR_MEM_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_cnt;
    logic       r_err;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_is_load   <= 1'b0;
            r_mode      <= 2'b00;
            r_rd        <= 4'h0;
            r_rp        <= 4'h0;
            r_mem_addr  <= 16'h0000;
            r_mem_wdata <= 8'h00;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_wr_data   <= 8'h00;
            r_wr_en     <= 1'b0;
            r_inc       <= 1'b0;
            r_dec       <= 1'b0;
            r_done      <= 1'b0;
`ifdef PTR_MEM_TIMEOUT_EN
            r_cnt       <= 8'h00;
            r_err       <= 1'b0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            r_inc   <= 1'b0;
            r_dec   <= 1'b0;
            r_done  <= 1'b0;
`ifdef PTR_MEM_TIMEOUT_EN
            r_err   <= 1'b0;
`endif
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_is_load <= i_is_load;
                        r_mode    <= i_mode;
                        r_rd      <= i_rd;
                        r_rp      <= i_rp & ~4'h1;
                        r_state   <= StLatch;
                    end
                end
                StLatch: begin
                    r_mem_addr  <= {i_ptr_hi, i_ptr_lo};
                    r_mem_wdata <= i_rd_data;
                    r_mem_req   <= 1'b1;
                    r_mem_we    <= !r_is_load;
`ifdef PTR_MEM_TIMEOUT_EN
                    r_cnt       <= 8'h00;
`endif
                    r_state     <= StReq;
                end
                StReq: begin
                    if (i_mem_ack) begin
                        if (r_is_load) begin
                            r_wr_data <= i_mem_rdata;
                        end
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_wr_en   <= r_is_load;
                        r_inc     <= w_do_inc;
                        r_dec     <= w_do_dec;
                        r_done    <= 1'b1;
                        r_state   <= StWb;
                    end
`ifdef PTR_MEM_TIMEOUT_EN
                    else if (r_cnt == TimeoutLast) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_err     <= 1'b1;
                        r_state   <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 8'h01;
                    end
`endif
                end
                StWb: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_rd_sel    = r_rd;
    assign o_ptr_sel   = r_rp;
    assign o_wr_en     = r_wr_en;
    assign o_wr_data   = r_wr_data;
    assign o_inc       = r_inc;
    assign o_dec       = r_dec;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_busy      = (r_state != StIdle);
    assign o_done      = r_done;
`ifdef PTR_MEM_TIMEOUT_EN
    assign o_err       = r_err;
`else
    assign o_err       = 1'b0;
`endif

endmodule

// File: doc/ptr_mem_unit.md
# ptr_mem_unit

Pointer-indirect load/store sequencer that sits between the CPU control path, the 16-entry register file and the data-memory bus. It reads a 16-bit pointer from an even/odd register pair, runs one memory read or write with a ready/ack handshake, and writes load data back into the register file. It optionally post-increments or post-decrements the pointer pair through the register file's `inc`/`dec` strobes.

## Interface
- `TIMEOUT_CYCLES`, 255: watchdog limit in REQ state; used only when `PTR_MEM_TIMEOUT_EN` is defined.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle command strobe; accepted only in IDLE.
- `is_load`  in  1  1 = load (mem→reg), 0 = store (reg→mem).
- `mode`  in  2  00 none, 01 post-inc, 10 post-dec, 11 reserved (treated as none).
- `rd`  in  4  data register: destination for loads, source for stores.
- `rp`  in  4  pointer pair base; bit 0 is ignored, so the pair is {rp|1, rp&~1}.
- `ptr_lo`, `ptr_hi`  in  8 each  register-file read of the pair (combinational).
- `rd_data`  in  8  register-file read of `rd_sel` (store data).
- `rd_sel`  out  4  register-file A/write select.
- `ptr_sel`  out  4  register-file B select; always even.
- `wr_en`, `wr_data[7:0]`  out  register-file write port.
- `inc`, `dec`  out  1 each  pointer-pair update strobes.
- `mem_addr`  out  16  {ptr_hi, ptr_lo} as latched.
- `mem_wdata`  out  8  store data.
- `mem_req`, `mem_we`  out  1 each  bus request and write qualifier.
- `mem_rdata`  in  8  read data; valid in the cycle `mem_ack` is high.
- `mem_ack`  in  1  bus completion.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  one-cycle timeout pulse; only present when `PTR_MEM_TIMEOUT_EN` is defined, otherwise tied to 0.

## Operation
- States: IDLE → LATCH → REQ → WB → IDLE.
- IDLE: on `start`, capture `is_load`, `mode`, `rd`, and `rp&~4'h1`. Go to LATCH.
- LATCH: drive `ptr_sel` and `rd_sel` from the captured values. Register `mem_addr = {ptr_hi, ptr_lo}` and `mem_wdata = rd_data`. Go to REQ.
- REQ: hold `mem_req=1` and `mem_we=!is_load`, with address and data stable. On `mem_ack`, capture `mem_rdata` and go to WB.
- WB:
  - Loads: `wr_en=1`, `wr_data` = captured data.
  - Pointer update: `inc` asserts for mode 01 and `dec` for mode 10, each for exactly one cycle. `inc` and `dec` are never both high.
  - Pulse `done` and go to IDLE.
- Hazard rule: for a load with `rd` in the pointer pair and mode ≠ 00, suppress `inc`/`dec`; the load value wins. Stores always update the pointer.
- Pointer arithmetic is 16-bit modulo: 0xFFFF+1 = 0x0000 and 0x0000−1 = 0xFFFF. The register file performs the arithmetic; this block only strobes.
- `start` while `busy` is ignored; no queueing.
- Reset, asserted at any time, forces IDLE and aborts an in-flight request immediately. Any later `mem_ack` is ignored.

## Timing
- Reset values: all outputs 0, with `rd_sel=0`, `ptr_sel=0`, `mem_addr=0x0000`, `mem_wdata=0`.
- Latency: `start` at cycle 0. `mem_req` rises at cycle 2. With ack at cycle N (N≥2), `done`/`wr_en`/`inc`/`dec` are high at cycle N+1. Minimum 4 cycles start-to-idle.
- `mem_req` falls in the cycle after ack. `mem_addr`, `mem_we` and `mem_wdata` stay constant while `mem_req` is high.
- `busy` rises the cycle after `start` and falls the cycle after `done`. A new `start` is accepted in the same cycle `busy` is low.

## Configuration
- `PTR_MEM_TIMEOUT_EN` defined: an 8-bit counter runs in REQ.
  - After `TIMEOUT_CYCLES` cycles without ack: drop `mem_req`, pulse `err`, return to IDLE.
  - No write-back, no `inc`/`dec`, no `done`.
- `PTR_MEM_TIMEOUT_EN` undefined: REQ waits indefinitely and `err` is constant 0.

## Test plan
- Load with post-inc: r2:r3 = 0x10FF, `rd`=5, ack after 3 wait cycles, `mem_rdata`=0xA5 -> r5=0xA5, pair=0x1100, `done` at start+6.
- Store with post-dec at wrap: pair 0x0000, r7=0x3C -> bus write to addr 0x0000 with data 0x3C, pair=0xFFFF.
- Hazard: load into r4 with `rp`=4, mode inc, `mem_rdata`=0x77 -> r4=0x77, r5 unchanged, `inc` never asserted.
- Busy rejection: second `start` issued during REQ -> ignored; exactly one `mem_req` transaction and one `done` pulse.
- Reset mid-REQ: `rst_n` low for 1 cycle, then ack -> all outputs 0, no write-back, FSM in IDLE.
- With `PTR_MEM_TIMEOUT_EN`: no ack -> `err` pulse 255 cycles after `mem_req` rises, `mem_req` low, no `done`, pointer unchanged.
